fetch_decode: RTL and testbench
===============================

Name: fetch_decode

Overview:
- Two-stage in-order front end: an instruction fetch stage with an internal word-addressed instruction memory, followed by an RV32I decode stage.
- Fetch and decode are chained with a valid/stall handshake; stall backpressure comes from the downstream execute stage.
- Sits between the core's reset/PC control and the execute stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (byte address, word aligned).
- MEM_WORDS, 256, depth of instruction memory in 32-bit words (power of two).

Ports:
- CLK  in  1  rising-edge clock
- RSTN  in  1  synchronous reset, active-high (despite the name); sampled on CLK rising edge
- NEXT_STALLED  in  1  execute stage cannot accept; holds decode output
- PC  out  32  current fetch PC
- INSTR  out  32  fetched instruction word (fetch→decode register)
- FETCH_VALID  out  1  INSTR holds a valid instruction
- FETCH_STALLED  out  1  fetch is holding; equals FETCH_VALID & DECODE_STALLED
- DEC_VALID  out  1  decode outputs valid
- DECODE_STALLED  out  1  decode is holding; equals DEC_VALID & NEXT_STALLED
- DEC_PC  out  32  PC of the decoded instruction
- OPCODE  out  7  instr[6:0]
- RD, RS1, RS2  out  5 each  instr[11:7], [19:15], [24:20]
- FUNCT3  out  3  instr[14:12]
- FUNCT7  out  7  instr[31:25]
- IMM  out  32  sign-extended immediate per format
- ITYPE  out  3  0=R,1=I,2=S,3=B,4=U,5=J,7=illegal
- ILLEGAL  out  1  opcode is not an RV32I base opcode

Behaviour:
- Memory: array named MEM of MEM_WORDS×32 bits, with no write port. It must be loadable with $readmemh through the hierarchical path <inst>.MEM. Read index = PC[log2(MEM_WORDS)+1:2]. Addresses beyond the depth wrap modulo MEM_WORDS.
- Reset (RSTN=1 at a clock edge):
  - PC=RESET_PC; INSTR=0; DEC_PC=0.
  - FETCH_VALID=0; DEC_VALID=0.
  - All decoded fields=0; ITYPE=0; ILLEGAL=0.
  - Reset takes priority over any stall; asserting reset mid-stream flushes both stages in one cycle.
- Fetch, each clock edge with RSTN=0 and FETCH_STALLED=0:
  - INSTR<=MEM[index(PC)]; FETCH_VALID<=1.
  - PC<=PC+4, wrapping at 2^32. The fetch stage also records the PC of the fetched word for decode.
- Fetch when FETCH_STALLED=1: PC, INSTR and FETCH_VALID hold.
- Decode, each clock edge with RSTN=0 and DECODE_STALLED=0:
  - DEC_VALID<=FETCH_VALID.
  - All field outputs and DEC_PC are registered from the fetch register.
- Decode when DECODE_STALLED=1: all decode outputs hold.
- Stall signals are combinational. No bubble is inserted when a stall releases; throughput is 1 instruction/cycle when unstalled.
- Latency from reset deassertion:
  - Edge 1: INSTR=MEM[0], FETCH_VALID=1.
  - Edge 2: decode of MEM[0] visible, DEC_VALID=1.
- Immediates:
  - I: instr[31:20] sign-extended.
  - S: {instr[31:25],instr[11:7]} sign-extended.
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0} sign-extended.
  - U: {instr[31:12],12'b0}.
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0} sign-extended.
  - R and illegal: 0.
- Opcode to ITYPE:
  - 0110011→R.
  - 0010011, 0000011, 1100111, 1110011, 0001111→I.
  - 0100011→S.
  - 1100011→B.
  - 0110111, 0010111→U.
  - 1101111→J.
  - Any other opcode→ITYPE=7 and ILLEGAL=1. The raw fields are still output; DEC_VALID is unaffected.

Test Plan:
- Reset then release, with NEXT_STALLED=0 and MEM[0]=0x00500093:
  - After edge 1: INSTR=0x00500093, FETCH_VALID=1, PC=4.
  - After edge 2: DEC_VALID=1, OPCODE=0x13, RD=1, RS1=0, IMM=5, ITYPE=1.
- Streaming:
  - MEM[1]=0x002081B3 → ITYPE=0, RD=3, RS1=1, RS2=2, FUNCT7=0.
  - MEM[2]=0xFE112E23 → ITYPE=2, RS1=2, RS2=1, IMM=0xFFFFFFFC.
  - MEM[3]=0x123452B7 → ITYPE=4, RD=5, IMM=0x12345000.
  - DEC_PC steps 0,4,8,12 on consecutive cycles.
- NEXT_STALLED held at 1 from reset:
  - Decode captures MEM[0] and holds; fetch captures MEM[1] and holds.
  - Steady state: PC=8, DECODE_STALLED=1, FETCH_STALLED=1.
  - Dropping NEXT_STALLED resumes with MEM[1] decoded next cycle; nothing is lost or duplicated.
- Illegal opcode MEM[0]=0x0000007F → ILLEGAL=1, ITYPE=7, IMM=0, DEC_VALID=1.
- Assert RSTN mid-stream while stalled → next edge: PC=RESET_PC, FETCH_VALID=0, DEC_VALID=0, INSTR=0.
- PC wrap: RESET_PC=(MEM_WORDS-1)*4 → fetches MEM[MEM_WORDS-1], then MEM[0]. A J-type word 0x0000006F decodes as ITYPE=5 with IMM=0.

Source files
------------

// File: rtl/fetch_decode.sv
// Two-stage RV32I front end: fetch from an internal read-only word memory,
// then register the decoded fields, both stages stalled by execute backpressure.
module fetch_decode #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 256
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        NEXT_STALLED,
    output logic [31:0] PC,
    output logic [31:0] INSTR,
    output logic        FETCH_VALID,
    output logic        FETCH_STALLED,
    output logic        DEC_VALID,
    output logic        DECODE_STALLED,
    output logic [31:0] DEC_PC,
    output logic [6:0]  OPCODE,
    output logic [4:0]  RD,
    output logic [4:0]  RS1,
    output logic [4:0]  RS2,
    output logic [2:0]  FUNCT3,
    output logic [6:0]  FUNCT7,
    output logic [31:0] IMM,
    output logic [2:0]  ITYPE,
    output logic        ILLEGAL
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [2:0] {
        IT_R   = 3'd0,
        IT_I   = 3'd1,
        IT_S   = 3'd2,
        IT_B   = 3'd3,
        IT_U   = 3'd4,
        IT_J   = 3'd5,
        IT_ILL = 3'd7
    } itype_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        itype_e      itype;
        logic        illegal;
    } dec_t;

    // NOTE: the instruction memory has no reset; it is loaded from outside and never written here.
    logic [31:0] MEM [0:MEM_WORDS-1];

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        fetch_valid_q, fetch_valid_d;
    dec_t        dec_q, dec_d;
    logic        decode_stalled;
    logic        fetch_stalled;

    assign decode_stalled = dec_q.valid & NEXT_STALLED;
    assign fetch_stalled  = fetch_valid_q & decode_stalled;

    // NOTE: every combinational output gets its hold value first so no path infers a latch.
    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_valid_d = fetch_valid_q;
        if (!fetch_stalled) begin
            instr_d       = MEM[pc_q[AW+1:2]];
            fetch_pc_d    = pc_q;
            fetch_valid_d = 1'b1;
            pc_d          = pc_q + 32'd4;
        end
    end

    always_comb begin
        dec_d = dec_q;
        if (!decode_stalled) begin
            dec_d.valid   = fetch_valid_q;
            dec_d.pc      = fetch_pc_q;
            dec_d.opcode  = instr_q[6:0];
            dec_d.rd      = instr_q[11:7];
            dec_d.rs1     = instr_q[19:15];
            dec_d.rs2     = instr_q[24:20];
            dec_d.funct3  = instr_q[14:12];
            dec_d.funct7  = instr_q[31:25];
            dec_d.illegal = 1'b0;
            unique case (instr_q[6:0])
                7'b0110011: begin
                    dec_d.itype = IT_R;
                    dec_d.imm   = 32'd0;
                end
                7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                    dec_d.itype = IT_I;
                    dec_d.imm   = {{20{instr_q[31]}}, instr_q[31:20]};
                end
                7'b0100011: begin
                    dec_d.itype = IT_S;
                    dec_d.imm   = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
                end
                7'b1100011: begin
                    dec_d.itype = IT_B;
                    dec_d.imm   = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                                   instr_q[30:25], instr_q[11:8], 1'b0};
                end
                7'b0110111, 7'b0010111: begin
                    dec_d.itype = IT_U;
                    dec_d.imm   = {instr_q[31:12], 12'd0};
                end
                7'b1101111: begin
                    dec_d.itype = IT_J;
                    dec_d.imm   = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                                   instr_q[20], instr_q[30:21], 1'b0};
                end
                default: begin
                    dec_d.itype   = IT_ILL;
                    dec_d.imm     = 32'd0;
                    dec_d.illegal = 1'b1;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RSTN) begin
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            fetch_pc_q    <= 32'd0;
            fetch_valid_q <= 1'b0;
            dec_q         <= '0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_valid_q <= fetch_valid_d;
            dec_q         <= dec_d;
        end
    end

    assign PC             = pc_q;
    assign INSTR          = instr_q;
    assign FETCH_VALID    = fetch_valid_q;
    assign FETCH_STALLED  = fetch_stalled;
    assign DEC_VALID      = dec_q.valid;
    assign DECODE_STALLED = decode_stalled;
    assign DEC_PC         = dec_q.pc;
    assign OPCODE         = dec_q.opcode;
    assign RD             = dec_q.rd;
    assign RS1            = dec_q.rs1;
    assign RS2            = dec_q.rs2;
    assign FUNCT3         = dec_q.funct3;
    assign FUNCT7         = dec_q.funct7;
    assign IMM            = dec_q.imm;
    assign ITYPE          = dec_q.itype;
    assign ILLEGAL        = dec_q.illegal;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: vector table streamed through the pipe, plus
// stall, reset-while-stalled and PC-wrap sequences on a second instance.
module tb_fetch_decode;
    logic        CLK;
    logic        RSTN;
    logic        NEXT_STALLED;

    logic [31:0] pc, instr, dec_pc, imm;
    logic        fetch_valid, fetch_stalled, dec_valid, decode_stalled, illegal;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3, itype;

    logic [31:0] w_pc, w_instr, w_dec_pc, w_imm;
    logic        w_fetch_valid, w_fetch_stalled, w_dec_valid, w_decode_stalled, w_illegal;
    logic [6:0]  w_opcode, w_funct7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_funct3, w_itype;

    int checks;
    int failures;

    fetch_decode #(.RESET_PC(32'h0000_0000), .MEM_WORDS(256)) dut (
        .CLK(CLK), .RSTN(RSTN), .NEXT_STALLED(NEXT_STALLED),
        .PC(pc), .INSTR(instr), .FETCH_VALID(fetch_valid), .FETCH_STALLED(fetch_stalled),
        .DEC_VALID(dec_valid), .DECODE_STALLED(decode_stalled), .DEC_PC(dec_pc),
        .OPCODE(opcode), .RD(rd), .RS1(rs1), .RS2(rs2), .FUNCT3(funct3), .FUNCT7(funct7),
        .IMM(imm), .ITYPE(itype), .ILLEGAL(illegal)
    );

    fetch_decode #(.RESET_PC(32'h0000_03FC), .MEM_WORDS(256)) wrp (
        .CLK(CLK), .RSTN(RSTN), .NEXT_STALLED(NEXT_STALLED),
        .PC(w_pc), .INSTR(w_instr), .FETCH_VALID(w_fetch_valid), .FETCH_STALLED(w_fetch_stalled),
        .DEC_VALID(w_dec_valid), .DECODE_STALLED(w_decode_stalled), .DEC_PC(w_dec_pc),
        .OPCODE(w_opcode), .RD(w_rd), .RS1(w_rs1), .RS2(w_rs2), .FUNCT3(w_funct3), .FUNCT7(w_funct7),
        .IMM(w_imm), .ITYPE(w_itype), .ILLEGAL(w_illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [2:0]  it;
        logic        il;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_dec(input int k);
        check($sformatf("v%0d dec_valid", k), 32'(dec_valid), 32'd1);
        check($sformatf("v%0d dec_pc", k), dec_pc, 32'(k * 4));
        check($sformatf("v%0d opcode", k), 32'(opcode), 32'(vecs[k].op));
        check($sformatf("v%0d rd", k), 32'(rd), 32'(vecs[k].rd));
        check($sformatf("v%0d rs1", k), 32'(rs1), 32'(vecs[k].rs1));
        check($sformatf("v%0d rs2", k), 32'(rs2), 32'(vecs[k].rs2));
        check($sformatf("v%0d funct3", k), 32'(funct3), 32'(vecs[k].f3));
        check($sformatf("v%0d funct7", k), 32'(funct7), 32'(vecs[k].f7));
        check($sformatf("v%0d imm", k), imm, vecs[k].imm);
        check($sformatf("v%0d itype", k), 32'(itype), 32'(vecs[k].it));
        check($sformatf("v%0d illegal", k), 32'(illegal), 32'(vecs[k].il));
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        RSTN         = 1'b1;
        NEXT_STALLED = 1'b0;

        //            instr          op     rd     rs1    rs2    f3    f7     imm            it    il
        vecs[0] = '{32'h00500093, 7'h13, 5'd1,  5'd0, 5'd5,  3'd0, 7'h00, 32'h00000005, 3'd1, 1'b0};
        vecs[1] = '{32'h002081B3, 7'h33, 5'd3,  5'd1, 5'd2,  3'd0, 7'h00, 32'h00000000, 3'd0, 1'b0};
        vecs[2] = '{32'hFE112E23, 7'h23, 5'd28, 5'd2, 5'd1,  3'd2, 7'h7F, 32'hFFFFFFFC, 3'd2, 1'b0};
        vecs[3] = '{32'h123452B7, 7'h37, 5'd5,  5'd8, 5'd3,  3'd5, 7'h09, 32'h12345000, 3'd4, 1'b0};
        vecs[4] = '{32'h0000007F, 7'h7F, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h00000000, 3'd7, 1'b1};
        vecs[5] = '{32'hFE208EE3, 7'h63, 5'd29, 5'd1, 5'd2,  3'd0, 7'h7F, 32'hFFFFFFFC, 3'd3, 1'b0};
        vecs[6] = '{32'h0000006F, 7'h6F, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h00000000, 3'd5, 1'b0};
        vecs[7] = '{32'hFFF00113, 7'h13, 5'd2,  5'd0, 5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 3'd1, 1'b0};
        vecs[8] = '{32'h00001517, 7'h17, 5'd10, 5'd0, 5'd0,  3'd1, 7'h00, 32'h00001000, 3'd4, 1'b0};

        for (int i = 0; i < 256; i++) begin
            dut.MEM[i] = 32'h0;
            wrp.MEM[i] = 32'h0;
        end
        for (int i = 0; i < NVEC; i++) dut.MEM[i] = vecs[i].instr;
        wrp.MEM[255] = 32'h0000006F;
        wrp.MEM[0]   = 32'h00500093;

        // Reset state
        tick();
        tick();
        check("rst pc", pc, 32'h0);
        check("rst instr", instr, 32'h0);
        check("rst fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst dec_valid", 32'(dec_valid), 32'd0);
        check("rst dec_pc", dec_pc, 32'h0);
        check("rst opcode", 32'(opcode), 32'd0);
        check("rst imm", imm, 32'h0);
        check("rst itype", 32'(itype), 32'd0);
        check("rst illegal", 32'(illegal), 32'd0);
        check("rst wrap pc", w_pc, 32'h3FC);

        // Edge 1 after release: first fetch only
        RSTN = 1'b0;
        tick();
        check("e1 instr", instr, 32'h00500093);
        check("e1 fetch_valid", 32'(fetch_valid), 32'd1);
        check("e1 pc", pc, 32'h4);
        check("e1 dec_valid", 32'(dec_valid), 32'd0);
        check("e1 wrap instr", w_instr, 32'h0000006F);
        check("e1 wrap pc", w_pc, 32'h400);

        // Streaming, one decode per cycle
        for (int k = 0; k < NVEC; k++) begin
            tick();
            check_dec(k);
            check($sformatf("v%0d fetch_stalled", k), 32'(fetch_stalled), 32'd0);
            if (k == 0) begin
                check("wrap j itype", 32'(w_itype), 32'd5);
                check("wrap j imm", w_imm, 32'h0);
                check("wrap j dec_pc", w_dec_pc, 32'h3FC);
                check("wrap instr mem0", w_instr, 32'h00500093);
            end
            if (k == 1) begin
                check("wrap dec_pc 400", w_dec_pc, 32'h400);
                check("wrap opcode", 32'(w_opcode), 32'h13);
                check("wrap imm", w_imm, 32'h5);
            end
        end

        // Mid-stream stall: both stages hold
        NEXT_STALLED = 1'b1;
        #1;
        check("stall decode_stalled", 32'(decode_stalled), 32'd1);
        check("stall fetch_stalled", 32'(fetch_stalled), 32'd1);
        tick();
        tick();
        check("hold dec_pc", dec_pc, 32'd32);
        check("hold opcode", 32'(opcode), 32'h17);
        check("hold pc", pc, 32'd40);
        check("hold instr", instr, 32'h0);

        // Reset while stalled flushes both stages
        RSTN = 1'b1;
        tick();
        check("flush pc", pc, 32'h0);
        check("flush fetch_valid", 32'(fetch_valid), 32'd0);
        check("flush dec_valid", 32'(dec_valid), 32'd0);
        check("flush instr", instr, 32'h0);
        check("flush decode_stalled", 32'(decode_stalled), 32'd0);

        // Stall held from reset release
        RSTN = 1'b0;
        tick();
        check("s1 pc", pc, 32'h4);
        check("s1 fetch_valid", 32'(fetch_valid), 32'd1);
        check("s1 dec_valid", 32'(dec_valid), 32'd0);
        check("s1 fetch_stalled", 32'(fetch_stalled), 32'd0);
        tick();
        check("s2 dec_valid", 32'(dec_valid), 32'd1);
        check("s2 dec_pc", dec_pc, 32'h0);
        check("s2 opcode", 32'(opcode), 32'h13);
        check("s2 pc", pc, 32'h8);
        check("s2 instr", instr, 32'h002081B3);
        tick();
        check("s3 pc", pc, 32'h8);
        check("s3 dec_pc", dec_pc, 32'h0);
        check("s3 instr", instr, 32'h002081B3);
        check("s3 decode_stalled", 32'(decode_stalled), 32'd1);
        check("s3 fetch_stalled", 32'(fetch_stalled), 32'd1);

        // Release: MEM[1] then MEM[2], no bubble, no duplicate
        NEXT_STALLED = 1'b0;
        tick();
        check("r1 dec_pc", dec_pc, 32'h4);
        check("r1 itype", 32'(itype), 32'd0);
        check("r1 rd", 32'(rd), 32'd3);
        check("r1 pc", pc, 32'hC);
        check("r1 instr", instr, 32'hFE112E23);
        tick();
        check("r2 dec_pc", dec_pc, 32'h8);
        check("r2 itype", 32'(itype), 32'd2);
        check("r2 imm", imm, 32'hFFFFFFFC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
